// File: rtl/exmem_pipe_reg_if.sv
// EX/MEM pipeline register bundle: EX-side fields in, MEM-side copies,
// forwarding hits and performance counters out.
interface exmem_pipe_reg_if #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int XFER_W = 4,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic              clr_cnt;

    logic              ex_valid;
    logic              ex_mem_we;
    logic              ex_mem2reg;
    logic              ex_reg_we;
    logic              ex_ldurb;
    logic [XFER_W-1:0] ex_xfer_size;
    logic [RD_W-1:0]   ex_rd;
    logic [DATA_W-1:0] ex_data;
    logic [DATA_W-1:0] ex_read_data2;
    logic [RD_W-1:0]   id_rn;
    logic [RD_W-1:0]   id_rm;

    logic              mem_valid;
    logic              mem_mem_we;
    logic              mem_mem2reg;
    logic              mem_reg_we;
    logic              mem_ldurb;
    logic [XFER_W-1:0] mem_xfer_size;
    logic [RD_W-1:0]   mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_read_data2;
    logic              fwd_rn_hit;
    logic              fwd_rm_hit;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output stall, flush, clr_cnt,
        output ex_valid, ex_mem_we, ex_mem2reg, ex_reg_we, ex_ldurb,
        output ex_xfer_size, ex_rd, ex_data, ex_read_data2, id_rn, id_rm,
        input  mem_valid, mem_mem_we, mem_mem2reg, mem_reg_we, mem_ldurb,
        input  mem_xfer_size, mem_rd, mem_data, mem_read_data2,
        input  fwd_rn_hit, fwd_rm_hit, stall_cnt, flush_cnt
    );

    modport slave (
        input  stall, flush, clr_cnt,
        input  ex_valid, ex_mem_we, ex_mem2reg, ex_reg_we, ex_ldurb,
        input  ex_xfer_size, ex_rd, ex_data, ex_read_data2, id_rn, id_rm,
        output mem_valid, mem_mem_we, mem_mem2reg, mem_reg_we, mem_ldurb,
        output mem_xfer_size, mem_rd, mem_data, mem_read_data2,
        output fwd_rn_hit, fwd_rm_hit, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with flush/stall control, MEM->EX forwarding
// detection and saturating stall/flush performance counters.
module exmem_pipe_reg #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int XFER_W = 4,
    parameter int CNT_W  = 16
) (
    input logic            clk,
    input logic            reset,
    exmem_pipe_reg_if.slave bus
);
    localparam logic [RD_W-1:0]  ZERO_REG = {RD_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic              valid_reg,  valid_next;
    logic              mem_we_reg, mem_we_next;
    logic              m2r_reg,    m2r_next;
    logic              reg_we_reg, reg_we_next;
    logic              ldurb_reg,  ldurb_next;
    logic [XFER_W-1:0] xfer_reg,   xfer_next;
    logic [RD_W-1:0]   rd_reg,     rd_next;
    logic [DATA_W-1:0] data_reg,   data_next;
    logic [DATA_W-1:0] rd2_reg,    rd2_next;

    // Flush clears only the controls so the bubble's payload stays as it was.
    always_comb begin
        valid_next  = valid_reg;
        mem_we_next = mem_we_reg;
        m2r_next    = m2r_reg;
        reg_we_next = reg_we_reg;
        ldurb_next  = ldurb_reg;
        xfer_next   = xfer_reg;
        rd_next     = rd_reg;
        data_next   = data_reg;
        rd2_next    = rd2_reg;
        if (bus.flush) begin
            valid_next  = 1'b0;
            mem_we_next = 1'b0;
            m2r_next    = 1'b0;
            reg_we_next = 1'b0;
            ldurb_next  = 1'b0;
        end else if (!bus.stall) begin
            valid_next  = bus.ex_valid;
            mem_we_next = bus.ex_valid & bus.ex_mem_we;
            m2r_next    = bus.ex_valid & bus.ex_mem2reg;
            reg_we_next = bus.ex_valid & bus.ex_reg_we;
            ldurb_next  = bus.ex_valid & bus.ex_ldurb;
            xfer_next   = bus.ex_xfer_size;
            rd_next     = bus.ex_rd;
            data_next   = bus.ex_data;
            rd2_next    = bus.ex_read_data2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg  <= 1'b0;
            mem_we_reg <= 1'b0;
            m2r_reg    <= 1'b0;
            reg_we_reg <= 1'b0;
            ldurb_reg  <= 1'b0;
            xfer_reg   <= '0;
            rd_reg     <= '0;
            data_reg   <= '0;
            rd2_reg    <= '0;
        end else begin
            valid_reg  <= valid_next;
            mem_we_reg <= mem_we_next;
            m2r_reg    <= m2r_next;
            reg_we_reg <= reg_we_next;
            ldurb_reg  <= ldurb_next;
            xfer_reg   <= xfer_next;
            rd_reg     <= rd_next;
            data_reg   <= data_next;
            rd2_reg    <= rd2_next;
        end
    end

    // Counter 0 counts effective stalls (flush wins), counter 1 counts flushes.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg  [2];
    logic [CNT_W-1:0] cnt_next [2];

    assign cnt_inc[0] = bus.stall & ~bus.flush;
    assign cnt_inc[1] = bus.flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_comb begin
                cnt_next[gi] = cnt_reg[gi];
                if (bus.clr_cnt)
                    cnt_next[gi] = '0;
                else if (cnt_inc[gi] && (cnt_reg[gi] != CNT_MAX))
                    cnt_next[gi] = cnt_reg[gi] + 1'b1;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    cnt_reg[gi] <= '0;
                else
                    cnt_reg[gi] <= cnt_next[gi];
            end
        end
    endgenerate

    // X31 reads as zero, so a write to it must never be forwarded.
    logic fwd_base;
    assign fwd_base       = valid_reg & reg_we_reg & (rd_reg != ZERO_REG);
    assign bus.fwd_rn_hit = fwd_base & (rd_reg == bus.id_rn);
    assign bus.fwd_rm_hit = fwd_base & (rd_reg == bus.id_rm);

    assign bus.mem_valid      = valid_reg;
    assign bus.mem_mem_we     = mem_we_reg;
    assign bus.mem_mem2reg    = m2r_reg;
    assign bus.mem_reg_we     = reg_we_reg;
    assign bus.mem_ldurb      = ldurb_reg;
    assign bus.mem_xfer_size  = xfer_reg;
    assign bus.mem_rd         = rd_reg;
    assign bus.mem_data       = data_reg;
    assign bus.mem_read_data2 = rd2_reg;
    assign bus.stall_cnt      = cnt_reg[0];
    assign bus.flush_cnt      = cnt_reg[1];
endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Directed bench for exmem_pipe_reg: load, stall, flush, forwarding,
// counter saturation/clear and asynchronous reset.
module tb_exmem_pipe_reg;
    localparam int DATA_W = 64;
    localparam int RD_W   = 5;
    localparam int XFER_W = 4;
    localparam int CNT_W  = 2;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    exmem_pipe_reg_if #(.DATA_W(DATA_W), .RD_W(RD_W), .XFER_W(XFER_W), .CNT_W(CNT_W)) bus ();

    exmem_pipe_reg #(.DATA_W(DATA_W), .RD_W(RD_W), .XFER_W(XFER_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.stall = 0; bus.flush = 0; bus.clr_cnt = 0;
        bus.ex_valid = 1; bus.ex_mem_we = 0; bus.ex_mem2reg = 0;
        bus.ex_reg_we = 1; bus.ex_ldurb = 0; bus.ex_xfer_size = 0;
        bus.ex_rd = 0; bus.ex_data = 64'h11; bus.ex_read_data2 = 0;
        bus.id_rn = 0; bus.id_rm = 0;

        // Reset state, including across a clock edge while held
        #3;
        chk("rst_valid", bus.mem_valid, 0);
        chk("rst_data", bus.mem_data, 0);
        chk("rst_scnt", bus.stall_cnt, 0);
        step();
        chk("rst_edge_data", bus.mem_data, 0);
        chk("rst_fwd_rn", bus.fwd_rn_hit, 0);
        $display("txn reset: valid=%0d data=%0h", bus.mem_valid, bus.mem_data);
        #2 reset = 1'b1;

        // Load
        bus.ex_valid = 1; bus.ex_reg_we = 1; bus.ex_rd = 3; bus.ex_data = 64'hDEAD;
        bus.ex_read_data2 = 64'h1234; bus.ex_xfer_size = 4'h8;
        bus.ex_mem2reg = 1; bus.ex_ldurb = 1;
        bus.id_rn = 3; bus.id_rm = 4;
        step();
        chk("ld_valid", bus.mem_valid, 1);
        chk("ld_rd", bus.mem_rd, 3);
        chk("ld_data", bus.mem_data, 64'hDEAD);
        chk("ld_rd2", bus.mem_read_data2, 64'h1234);
        chk("ld_xfer", bus.mem_xfer_size, 8);
        chk("ld_m2r", bus.mem_mem2reg, 1);
        chk("ld_ldurb", bus.mem_ldurb, 1);
        chk("ld_fwd_rn", bus.fwd_rn_hit, 1);
        chk("ld_fwd_rm", bus.fwd_rm_hit, 0);
        bus.id_rm = 3;
        #1;
        chk("ld_fwd_rm_comb", bus.fwd_rm_hit, 1);
        $display("txn load: rd=%0d data=%0h fwd_rn=%0d", bus.mem_rd, bus.mem_data, bus.fwd_rn_hit);

        // Stall three cycles with changing EX data
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus.ex_data = 64'h100 + 64'(i);
            step();
        end
        chk("stall_data", bus.mem_data, 64'hDEAD);
        chk("stall_valid", bus.mem_valid, 1);
        chk("stall_cnt3", bus.stall_cnt, 3);
        chk("stall_fcnt", bus.flush_cnt, 0);
        $display("txn stall: data=%0h stall_cnt=%0d", bus.mem_data, bus.stall_cnt);

        // Clear counters while loading an invalid instruction
        bus.stall = 0; bus.clr_cnt = 1;
        bus.ex_valid = 0; bus.ex_reg_we = 1; bus.ex_mem2reg = 1; bus.ex_ldurb = 1;
        bus.ex_rd = 7; bus.ex_data = 64'h55; bus.id_rn = 7;
        step();
        bus.clr_cnt = 0;
        chk("inv_valid", bus.mem_valid, 0);
        chk("inv_reg_we", bus.mem_reg_we, 0);
        chk("inv_m2r", bus.mem_mem2reg, 0);
        chk("inv_ldurb", bus.mem_ldurb, 0);
        chk("inv_rd", bus.mem_rd, 7);
        chk("inv_data", bus.mem_data, 64'h55);
        chk("inv_fwd_rn", bus.fwd_rn_hit, 0);
        chk("clr_scnt", bus.stall_cnt, 0);
        $display("txn invalid+clr: valid=%0d rd=%0d stall_cnt=%0d", bus.mem_valid, bus.mem_rd, bus.stall_cnt);

        // Store loaded, then flush together with stall
        bus.ex_valid = 1; bus.ex_mem_we = 1; bus.ex_reg_we = 0; bus.ex_mem2reg = 0;
        bus.ex_ldurb = 0; bus.ex_rd = 9; bus.ex_data = 64'hA0; bus.ex_read_data2 = 64'hBEEF;
        step();
        chk("st_mem_we", bus.mem_mem_we, 1);
        bus.flush = 1; bus.stall = 1; bus.ex_data = 64'hFF; bus.ex_rd = 1;
        step();
        chk("fl_valid", bus.mem_valid, 0);
        chk("fl_mem_we", bus.mem_mem_we, 0);
        chk("fl_data", bus.mem_data, 64'hA0);
        chk("fl_rd2", bus.mem_read_data2, 64'hBEEF);
        chk("fl_rd", bus.mem_rd, 9);
        chk("fl_fcnt", bus.flush_cnt, 1);
        chk("fl_scnt", bus.stall_cnt, 0);
        $display("txn flush+stall: valid=%0d data=%0h flush_cnt=%0d", bus.mem_valid, bus.mem_data, bus.flush_cnt);

        // XZR destination never forwards
        bus.flush = 0; bus.stall = 0;
        bus.ex_valid = 1; bus.ex_mem_we = 0; bus.ex_reg_we = 1; bus.ex_rd = 31;
        bus.ex_data = 64'h31; bus.id_rn = 31; bus.id_rm = 31;
        step();
        chk("xzr_valid", bus.mem_valid, 1);
        chk("xzr_rd", bus.mem_rd, 31);
        chk("xzr_fwd_rn", bus.fwd_rn_hit, 0);
        chk("xzr_fwd_rm", bus.fwd_rm_hit, 0);
        $display("txn xzr: rd=%0d fwd_rn=%0d fwd_rm=%0d", bus.mem_rd, bus.fwd_rn_hit, bus.fwd_rm_hit);

        // Saturation: five stall cycles on a 2-bit counter
        bus.stall = 1;
        for (int i = 0; i < 5; i++) step();
        chk("sat_scnt", bus.stall_cnt, 3);
        chk("sat_data", bus.mem_data, 64'h31);
        bus.clr_cnt = 1;
        step();
        chk("satclr_scnt", bus.stall_cnt, 0);
        chk("satclr_fcnt", bus.flush_cnt, 0);
        bus.clr_cnt = 0;
        step();
        chk("post_clr_scnt", bus.stall_cnt, 1);
        $display("txn saturate+clr: stall_cnt=%0d", bus.stall_cnt);

        // Asynchronous reset between edges
        bus.stall = 0; bus.ex_valid = 1; bus.ex_reg_we = 1; bus.ex_rd = 5;
        bus.ex_data = 64'h77; bus.id_rn = 5;
        step();
        chk("pre_rst_valid", bus.mem_valid, 1);
        chk("pre_rst_fwd", bus.fwd_rn_hit, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", bus.mem_valid, 0);
        chk("arst_data", bus.mem_data, 0);
        chk("arst_rd", bus.mem_rd, 0);
        chk("arst_scnt", bus.stall_cnt, 0);
        chk("arst_fwd_rn", bus.fwd_rn_hit, 0);
        $display("txn async reset: valid=%0d data=%0h", bus.mem_valid, bus.mem_data);
        #2 reset = 1'b1;

        // First edge after release with stall held: zeros held, stall counted
        bus.stall = 1;
        step();
        chk("rel_data", bus.mem_data, 0);
        chk("rel_valid", bus.mem_valid, 0);
        chk("rel_scnt", bus.stall_cnt, 1);
        $display("txn release+stall: data=%0h stall_cnt=%0d", bus.mem_data, bus.stall_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
